fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Controller that sequences the 32-bit program counter register and the instruction-fetch handshake. Every cycle it drives the PC's load enable and load address, choosing between boot vector, sequential +4, branch redirect, trap redirect and hold. It issues requests to instruction memory and flags a fetch fault when memory stops answering. It sits between the PC register, the instruction memory port and the decode/execute stages.

## Interface

- `RESET_VEC`, `32'h0000_0000`: address loaded into the PC in the first cycle after reset.
- `TRAP_VEC`, `32'h0000_0100`: address loaded on `trap_req`.
- `TIMEOUT`, `16`: consecutive un-acknowledged request cycles before a fault; legal range 2..65535.

Ports (clock and reset first):

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_` input 1: asynchronous, active-low reset.
- `addr_current` input 32: current PC value, fed back from the PC register.
- `stall` input 1: downstream cannot accept an instruction this cycle.
- `branch_taken` input 1: branch/jump redirect request.
- `branch_target` input 32: redirect address, valid with `branch_taken`.
- `trap_req` input 1: trap redirect request.
- `imem_ready` input 1: instruction memory accepts/completes the current request.
- `ena_pc` output 1: PC load enable.
- `addr_load` output 32: PC next value.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch address; always equals `addr_current`.
- `if_valid` output 1: the fetch at `addr_current` completed and is handed to decode this cycle.
- `fetch_fault` output 1: timeout fault; high while in FAULT.
- `misalign` output 1: misaligned-branch trap pulse; see Configuration.

## Operation

- The PC register clears itself whenever its enable is low. `ena_pc` is therefore held at 1 in every state, including during reset. A hold is done by driving `addr_load = addr_current`.
- States: BOOT, FETCH, FAULT. Reset forces BOOT and `wait_cnt = 0`.
- **BOOT**
  - Outputs: `addr_load = RESET_VEC`, `imem_req = 0`.
  - Always goes to FETCH on the next edge.
- **FETCH**
  - `imem_req = !stall`.
  - `addr_load` selection, in priority order:
    1. `trap_req`: `TRAP_VEC`.
    2. `branch_taken`: `{branch_target[31:2], 2'b00}`.
    3. `imem_req && imem_ready`: `addr_current + 4`, with 32-bit wrap (`32'hFFFF_FFFC` goes to `0`).
    4. Otherwise: `addr_current` (hold).
- **`if_valid`** = `imem_req && imem_ready && !trap_req && !branch_taken`. A redirect in the same cycle squashes the completed fetch.
- **`wait_cnt`**
  - Increments on cycles with `imem_req && !imem_ready` and no redirect.
  - Clears on any handshake or redirect.
  - Holds its value during `stall`.
  - When it would reach `TIMEOUT`, the state goes to FAULT and the counter clears.
- **FAULT**
  - Outputs: `imem_req = 0`, `fetch_fault = 1`, `addr_load = addr_current`.
  - `branch_taken` is ignored.
  - `trap_req` loads `TRAP_VEC` and returns the state to FETCH.
- Reset mid-operation: state, counter and all outputs take their reset values immediately (asynchronous). An in-flight memory request is abandoned.

## Timing

- Values during reset: `ena_pc = 1`, `addr_load = RESET_VEC`, `imem_req = 0`, `if_valid = 0`, `fetch_fault = 0`, `misalign = 0`.
- After `rst_` rises:
  - Edge 1: the PC loads `RESET_VEC`.
  - Cycle 1: FETCH with `imem_addr = RESET_VEC`.
- Zero-wait memory (`imem_ready` held at 1): one `if_valid` per cycle. The PC advances by 4 each edge.
- Redirect latency is 1 cycle. The target appears on `addr_current`/`imem_addr` in the cycle after `trap_req`/`branch_taken` is sampled.
- All outputs are combinational from state, `wait_cnt` and inputs. There is no request-to-output register stage.
- Fault timing: with `imem_ready` low for `TIMEOUT` consecutive request cycles, `fetch_fault` rises in the next cycle.

## Configuration

`FETCH_MISALIGN_TRAP_EN`:

- **Defined:**
  - `branch_taken` with `branch_target[1:0] != 0` (and no `trap_req`) loads `TRAP_VEC` instead of the target.
  - `misalign` pulses high for that cycle.
  - `if_valid` is squashed.
- **Undefined:**
  - Target bits `[1:0]` are cleared and used.
  - `misalign` is tied to 0.

## Test plan

- Reset release, `RESET_VEC = 0`, `imem_ready = 1` for 4 cycles -> `imem_addr` = 0, 4, 8, 12; `if_valid` = 1 each cycle.
- `imem_ready` low for 2 cycles at PC `0x20`, then high -> PC holds `0x20` through the wait, then `if_valid` = 1 and the next PC is `0x24`.
- `stall = 1` at PC `0x40` for 3 cycles -> `imem_req = 0`, PC holds `0x40`, `wait_cnt` holds, no fault.
- `branch_taken` and `trap_req` together with target `0x80` -> next PC `0x100`; `if_valid` = 0 that cycle.
- `imem_ready = 0` for 16 request cycles -> FAULT, `fetch_fault = 1`, PC frozen. Then `trap_req` -> PC `0x100`, state FETCH, `fetch_fault = 0`.
- Branch to `0x86` -> with `FETCH_MISALIGN_TRAP_EN`: PC `0x100`, `misalign` pulses. Without it: PC `0x84`.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// PC-sequencing and instruction-fetch handshake bundle between fetch_sequencer
// (master) and the PC register / instruction memory / pipeline side (slave).
interface fetch_sequencer_if;
    logic [31:0] addr_current;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap_req;
    logic        imem_ready;
    logic        ena_pc;
    logic [31:0] addr_load;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic        fetch_fault;
    logic        misalign;

    modport master (
        input  addr_current, stall, branch_taken, branch_target, trap_req, imem_ready,
        output ena_pc, addr_load, imem_req, imem_addr, if_valid, fetch_fault, misalign
    );

    modport slave (
        output addr_current, stall, branch_taken, branch_target, trap_req, imem_ready,
        input  ena_pc, addr_load, imem_req, imem_addr, if_valid, fetch_fault, misalign
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC next-value / fetch-handshake sequencer with request timeout fault.
// Optional: `define FETCH_MISALIGN_TRAP_EN to trap on misaligned branch targets.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter int          TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst_,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, FAULT} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_nxt;
    logic        req, handshake, redirect, mis_br;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign mis_br = bus.branch_taken && !bus.trap_req && (bus.branch_target[1:0] != 2'b00);
`else
    assign mis_br = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= BOOT;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_nxt        = wait_cnt;
        req             = 1'b0;
        handshake       = 1'b0;
        redirect        = 1'b0;
        bus.addr_load   = bus.addr_current;
        bus.if_valid    = 1'b0;
        bus.fetch_fault = 1'b0;
        bus.misalign    = 1'b0;
        unique case (state)
            BOOT: begin
                bus.addr_load = RESET_VEC;
                state_nxt     = FETCH;
            end
            FETCH: begin
                req          = !bus.stall;
                handshake    = req && bus.imem_ready;
                redirect     = bus.trap_req || bus.branch_taken;
                bus.misalign = mis_br;
                if (bus.trap_req || mis_br)
                    bus.addr_load = TRAP_VEC;
                else if (bus.branch_taken)
                    bus.addr_load = bus.branch_target & ~32'h3;
                else if (handshake)
                    bus.addr_load = bus.addr_current + 32'd4;
                bus.if_valid = handshake && !redirect;
                // Stalled cycles issue no request, so the counter simply holds.
                if (redirect || handshake) begin
                    wait_nxt = '0;
                end else if (req) begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_nxt  = '0;
                        state_nxt = FAULT;
                    end else begin
                        wait_nxt = wait_cnt + 16'd1;
                    end
                end
            end
            FAULT: begin
                bus.fetch_fault = 1'b1;
                if (bus.trap_req) begin
                    bus.addr_load = TRAP_VEC;
                    state_nxt     = FETCH;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    // The PC register clears whenever its enable drops, so it is never released.
    assign bus.ena_pc    = 1'b1;
    assign bus.imem_req  = req;
    assign bus.imem_addr = bus.addr_current;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: driver pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_fetch_sequencer;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
    localparam int          TIMEOUT   = 16;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rst_ = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if bus();

    fetch_sequencer #(.RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    // PC register: clears when its enable is low.
    logic [31:0] pc_reg = 32'hDEAD_BEEF;
    always_ff @(posedge clk) pc_reg <= bus.ena_pc ? bus.addr_load : 32'h0;
    assign bus.addr_current = pc_reg;

    typedef struct {
        logic        ena;
        logic [31:0] addr_load;
        logic        req;
        logic [31:0] imem_addr;
        logic        valid;
        logic        fault;
        logic        mis;
        bit          chk_addr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // reference model: expected PC, mode, and consecutive-miss count
    bit          m_boot  = 1'b1;
    bit          m_fault = 1'b0;
    int          m_wait  = 0;
    logic [31:0] m_pc    = 32'h0;
    bit          m_pc_ok = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ena_pc", {31'b0, bus.ena_pc}, {31'b0, e.ena});
            chk("addr_load", bus.addr_load, e.addr_load);
            chk("imem_req", {31'b0, bus.imem_req}, {31'b0, e.req});
            chk("if_valid", {31'b0, bus.if_valid}, {31'b0, e.valid});
            chk("fetch_fault", {31'b0, bus.fetch_fault}, {31'b0, e.fault});
            chk("misalign", {31'b0, bus.misalign}, {31'b0, e.mis});
            if (e.chk_addr) chk("imem_addr", bus.imem_addr, e.imem_addr);
        end
    end

    task automatic step(bit r, bit st, bit br, logic [31:0] bt, bit tr, bit rdy);
        exp_t        e;
        bit          mis, hs;
        logic [1:0]  lo;
        @(posedge clk);
        #1;
        rst_              = r;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        bus.trap_req      = tr;
        bus.imem_ready    = rdy;
        e.ena = 1'b1; e.req = 1'b0; e.valid = 1'b0; e.fault = 1'b0; e.mis = 1'b0;
        e.imem_addr = m_pc; e.chk_addr = m_pc_ok; e.addr_load = m_pc;
        if (!r) begin
            e.addr_load = RESET_VEC;
            m_boot = 1'b1; m_fault = 1'b0; m_wait = 0;
        end else if (m_boot) begin
            e.addr_load = RESET_VEC;
            m_boot = 1'b0;
        end else if (m_fault) begin
            e.fault = 1'b1;
            if (tr) begin
                e.addr_load = TRAP_VEC;
                m_fault = 1'b0;
            end
        end else begin
            lo  = bt[1:0];
            mis = MIS_EN && br && !tr && (lo != 2'b00);
            e.req = !st;
            e.mis = mis;
            hs = e.req && rdy;
            if (tr || mis)   e.addr_load = TRAP_VEC;
            else if (br)     e.addr_load = {bt[31:2], 2'b00};
            else if (hs)     e.addr_load = m_pc + 32'd4;
            e.valid = hs && !tr && !br;
            if (tr || br || hs) m_wait = 0;
            else if (e.req) begin
                if (m_wait + 1 == TIMEOUT) begin
                    m_fault = 1'b1;
                    m_wait  = 0;
                end else begin
                    m_wait++;
                end
            end
        end
        q.push_back(e);
        m_pc    = e.addr_load;
        m_pc_ok = 1'b1;
    endtask

    task automatic run(bit st, bit rdy);
        step(1'b1, st, 1'b0, 32'h0, 1'b0, rdy);
    endtask

    task automatic branch(logic [31:0] t);
        step(1'b1, 1'b0, 1'b1, t, 1'b0, 1'b1);
    endtask

    initial begin
        bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
        bus.trap_req = 0; bus.imem_ready = 1;
        step(1'b0, 0, 0, 0, 0, 1);
        step(1'b0, 0, 0, 0, 0, 1);
        step(1'b1, 0, 0, 0, 0, 1);                       // BOOT
        repeat (4) run(1'b0, 1'b1);                       // 0,4,8,12
        branch(32'h20);
        run(1'b0, 1'b0); run(1'b0, 1'b0); run(1'b0, 1'b1); run(1'b0, 1'b1);
        branch(32'h40);
        repeat (10) run(1'b0, 1'b0);
        repeat (3) run(1'b1, 1'b0);                       // stall holds wait count
        repeat (6) run(1'b0, 1'b0);                       // 16th request -> FAULT
        step(1'b1, 0, 1'b1, 32'h80, 0, 1);                // branch ignored in FAULT
        run(1'b0, 1'b1);
        step(1'b1, 0, 0, 0, 1'b1, 1);                     // trap leaves FAULT
        run(1'b0, 1'b1);
        step(1'b1, 0, 1'b1, 32'h80, 1'b1, 1);             // trap beats branch
        run(1'b0, 1'b1);
        repeat (16) run(1'b0, 1'b0);
        run(1'b0, 1'b1);
        step(1'b1, 0, 0, 0, 1'b1, 0);
        branch(32'h86);                                   // misaligned target
        run(1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            bit          r, st, br, tr, rdy;
            logic [31:0] bt;
            r   = ($urandom_range(0, 399) != 0);
            st  = ($urandom_range(0, 99) < 20);
            br  = ($urandom_range(0, 99) < 8);
            tr  = ($urandom_range(0, 99) < 3);
            rdy = ($urandom_range(0, 99) < 60);
            bt  = $urandom() & 32'h0000_03FF;
            if ($urandom_range(0, 99) < 5) bt = $urandom();
            step(r, st, br, bt, tr, rdy);
        end
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
